// File: rtl/mcu_strip_scheduler.sv
// Streams each finished 8-row strip out of the double-buffered EBR store in MCU order.
// A swap of the ingester's front buffer starts readout; a swap during readout aborts and restarts it.
module mcu_strip_scheduler #(
  parameter int NUM_EBR        = 5,
  parameter int EBR_SIZE       = 512,
  parameter int MCUS_PER_STRIP = 40
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        i_strip_buffer_sel,
  output logic [2:0]                  o_rd_block_select,
  output logic                        o_rd_buffer_select,
  output logic [$clog2(EBR_SIZE)-1:0] o_rd_addr,
  output logic                        o_rd_en,
  input  logic [7:0]                  i_rd_data,
  output logic                        o_px_valid,
  input  logic                        i_px_ready,
  output logic [7:0]                  o_px_data,
  output logic                        o_px_mcu_first,
  output logic                        o_px_mcu_last,
  output logic [5:0]                  o_px_mcu_index,
  output logic                        o_strip_done,
  output logic                        o_overrun,
  output logic                        o_overrun_sticky,
  output logic                        o_busy
);

  localparam logic [2:0] BLK_LAST = 3'(NUM_EBR - 1);
  localparam logic [5:0] MCU_LAST = 6'(MCUS_PER_STRIP - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sel_prev;
  logic        r_buffer;
  logic [5:0]  r_idx;
  logic [2:0]  r_blk;
  logic [2:0]  r_row;
  logic [5:0]  r_mcu;
  logic        r_inflight;
  logic [7:0]  r_if_tag;
  logic [15:0] r_fifo [0:1];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic        r_strip_done;
  logic        r_overrun;
  logic        r_overrun_sticky;

  logic        w_swap;
  logic        w_pop;
  logic        w_room;
  logic        w_issue;
  logic        w_last_issue;
  logic        w_final_pop;
  logic        w_overrun_det;
  logic [15:0] w_head;

  assign w_swap       = (i_strip_buffer_sel != r_sel_prev);
  assign w_head       = r_fifo[r_rptr];
  assign w_pop        = o_px_valid & i_px_ready;
  // Counting the slot freed by this cycle's pop is what keeps the pipe at one pixel per clock.
  assign w_room       = ({1'b0, r_count} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
  assign w_issue      = (r_state == S_RUN) && w_room;
  assign w_last_issue = w_issue && (r_mcu == MCU_LAST) && (r_idx == 6'd63);
  assign w_final_pop  = (r_state == S_DRAIN) && w_pop && (r_count == 2'd1) && !r_inflight;

  always_ff @(posedge clock) begin
    r_sel_prev <= i_strip_buffer_sel;
    if (nreset) begin
      r_state          <= S_IDLE;
      r_strip_done     <= 1'b0;
      r_overrun        <= 1'b0;
      r_overrun_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_strip_done <= w_final_pop;
      r_overrun    <= w_overrun_det;
      if (w_overrun_det) r_overrun_sticky <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_swap) w_state_next = S_RUN;
      S_RUN:   if (w_swap) w_state_next = S_RUN;
               else if (w_last_issue) w_state_next = S_DRAIN;
      S_DRAIN: if (w_swap) w_state_next = S_RUN;
               else if (w_final_pop) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_rd_en       = w_issue;
    o_busy        = (r_state != S_IDLE);
    // A swap landing on the final pop is a clean hand-off, not an overrun.
    w_overrun_det = w_swap && (r_state != S_IDLE) && !w_final_pop;
  end

  always_ff @(posedge clock) begin
    if (nreset || w_swap) begin
      r_idx <= 6'd0;
      r_blk <= 3'd0;
      r_row <= 3'd0;
      r_mcu <= 6'd0;
    end else if (w_issue) begin
      r_idx <= r_idx + 6'd1;
      if (r_idx == 6'd63) begin
        r_mcu <= r_mcu + 6'd1;
        if (r_blk == BLK_LAST) begin
          r_blk <= 3'd0;
          r_row <= r_row + 3'd1;
        end else begin
          r_blk <= r_blk + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (nreset) r_buffer <= 1'b0;
    else if (w_swap) r_buffer <= r_sel_prev;
  end

  always_ff @(posedge clock) begin
    if (nreset || w_swap) begin
      r_inflight <= 1'b0;
      r_if_tag   <= 8'd0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_if_tag <= {r_idx == 6'd0, r_idx == 6'd63, r_mcu};
      if (r_inflight) begin
        r_fifo[r_wptr] <= {i_rd_data, r_if_tag};
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign o_rd_block_select  = r_blk;
  assign o_rd_addr          = {r_row, r_idx};
  assign o_rd_buffer_select = r_buffer;
  assign o_px_valid         = (r_count != 2'd0);
  assign o_px_data          = w_head[15:8];
  assign o_px_mcu_first     = w_head[7];
  assign o_px_mcu_last      = w_head[6];
  assign o_px_mcu_index     = w_head[5:0];
  assign o_strip_done       = r_strip_done;
  assign o_overrun          = r_overrun;
  assign o_overrun_sticky   = r_overrun_sticky;

endmodule

// File: tb/tb_mcu_strip_scheduler.sv
// Directed bench for mcu_strip_scheduler: EBR memory model plus a pixel scoreboard fed at each swap.
module tb_mcu_strip_scheduler;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
    logic [5:0] m;
  } px_t;

  logic       clock = 1'b0;
  logic       nreset;
  logic       strip_buffer_sel;
  logic [2:0] rd_block_select;
  logic       rd_buffer_select;
  logic [8:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data = 8'd0;
  logic       px_valid;
  logic       px_ready;
  logic [7:0] px_data;
  logic       px_mcu_first;
  logic       px_mcu_last;
  logic [5:0] px_mcu_index;
  logic       strip_done;
  logic       overrun;
  logic       overrun_sticky;
  logic       busy;

  always #5 clock = ~clock;

  mcu_strip_scheduler dut (
    .clock              (clock),
    .nreset             (nreset),
    .i_strip_buffer_sel (strip_buffer_sel),
    .o_rd_block_select  (rd_block_select),
    .o_rd_buffer_select (rd_buffer_select),
    .o_rd_addr          (rd_addr),
    .o_rd_en            (rd_en),
    .i_rd_data          (rd_data),
    .o_px_valid         (px_valid),
    .i_px_ready         (px_ready),
    .o_px_data          (px_data),
    .o_px_mcu_first     (px_mcu_first),
    .o_px_mcu_last      (px_mcu_last),
    .o_px_mcu_index     (px_mcu_index),
    .o_strip_done       (strip_done),
    .o_overrun          (overrun),
    .o_overrun_sticky   (overrun_sticky),
    .o_busy             (busy)
  );

  function automatic logic [7:0] ebr_byte(input logic b, input logic [2:0] blk, input logic [8:0] a);
    logic [7:0] v;
    v = a[7:0] * 8'd13 + {5'd0, blk} * 8'd37 + (a[8] ? 8'd91 : 8'd0) + (b ? 8'd149 : 8'd0);
    return v;
  endfunction

  // Registered-read EBR model: data appears the cycle after rd_en.
  always @(posedge clock) begin
    if (rd_en) rd_data <= ebr_byte(rd_buffer_select, rd_block_select, rd_addr);
  end

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_no = 0;
  int   rd_total = 0;
  int   rd_issue = 0;
  int   done_count = 0;
  int   ovr_count = 0;
  int   strip_acc = 0;
  int   first_acc = -1;
  int   last_acc_cyc = -10;
  int   first_rd = -1;
  int   first_valid = -1;
  int   swap_cyc = 0;
  bit   rnd_ready = 1'b0;
  logic exp_buf = 1'b0;
  px_t  q[$];

  logic       s_valid, s_first, s_last, s_done, s_ovr, s_sticky, s_busy, s_rden, s_buf;
  logic [7:0] s_data;
  logic [5:0] s_mcu;
  logic [8:0] s_addr;
  logic [2:0] s_blk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_strip(input logic b);
    px_t e;
    for (int m = 0; m < 40; m++) begin
      for (int i = 0; i < 64; i++) begin
        e.d = ebr_byte(b, 3'(m % 5), 9'((m / 5) * 64 + i));
        e.f = (i == 0);
        e.l = (i == 63);
        e.m = 6'(m);
        q.push_back(e);
      end
    end
  endtask

  // One clock: apply inputs, sample outputs mid-cycle, score accepts, advance to just after the edge.
  task automatic cyc();
    px_t e;
    if (rnd_ready) px_ready = 1'($urandom_range(0, 1));
    #1;
    cyc_no++;
    s_valid = px_valid;  s_data = px_data;  s_first = px_mcu_first; s_last = px_mcu_last;
    s_mcu = px_mcu_index; s_done = strip_done; s_ovr = overrun; s_sticky = overrun_sticky;
    s_busy = busy; s_rden = rd_en; s_addr = rd_addr; s_blk = rd_block_select; s_buf = rd_buffer_select;
    if (rd_en) begin
      rd_total++;
      chk("rd_buffer", rd_buffer_select, exp_buf);
      if (rd_issue == 7 * 64 + 10) begin
        chk("mcu7_px10_block", rd_block_select, 3'd2);
        chk("mcu7_px10_addr", rd_addr, 9'd74);
      end
      if (first_rd < 0) first_rd = cyc_no;
      rd_issue++;
    end
    if (px_valid && first_valid < 0) first_valid = cyc_no;
    if (px_valid && px_ready) begin
      chk("queue_nonempty", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("px_data", px_data, e.d);
        chk("px_first", px_mcu_first, e.f);
        chk("px_last", px_mcu_last, e.l);
        chk("px_mcu", px_mcu_index, e.m);
      end
      strip_acc++;
      if (first_acc < 0) first_acc = cyc_no;
      last_acc_cyc = cyc_no;
    end
    if (strip_done) begin
      done_count++;
      chk("done_after_last_accept", 32'(cyc_no - last_acc_cyc), 32'd1);
    end
    if (overrun) ovr_count++;
    @(posedge clock);
    #1;
  endtask

  task automatic start_strip();
    logic nb;
    nb = strip_buffer_sel;
    strip_buffer_sel = ~strip_buffer_sel;
    cyc();
    swap_cyc = cyc_no;
    q.delete();
    push_strip(nb);
    exp_buf = nb;
    strip_acc = 0;
    rd_issue = 0;
    first_rd = -1;
    first_valid = -1;
    first_acc = -1;
  endtask

  task automatic run_to_done(input int budget);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < budget) begin
      cyc();
      n++;
    end
    chk("done_within_budget", done_count != start, 1'b1);
    $display("strip buf=%0d accepted=%0d done=%0d overruns=%0d cycle=%0d",
             exp_buf, strip_acc, done_count, ovr_count, cyc_no);
  endtask

  int d0, o0, rd0, n;
  logic [15:0] hold;

  initial begin
    nreset = 1'b1;
    strip_buffer_sel = 1'b0;
    px_ready = 1'b1;
    @(posedge clock);
    #1;

    // Reset state
    repeat (3) cyc();
    chk("rst_rd_en", s_rden, 1'b0);
    chk("rst_px_valid", s_valid, 1'b0);
    chk("rst_strip_done", s_done, 1'b0);
    chk("rst_overrun", s_ovr, 1'b0);
    chk("rst_sticky", s_sticky, 1'b0);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_rd_addr", s_addr, 9'd0);
    chk("rst_rd_block", s_blk, 3'd0);
    chk("rst_rd_buffer", s_buf, 1'b0);
    nreset = 1'b0;
    repeat (3) cyc();
    chk("idle_after_reset", {s_busy, s_rden, s_valid}, 3'b000);

    // Full-rate strip from buffer 0
    d0 = done_count;
    start_strip();
    run_to_done(3000);
    chk("b_first_rd_latency", 32'(first_rd - swap_cyc), 32'd1);
    chk("b_first_valid_latency", 32'(first_valid - first_rd), 32'd2);
    chk("b_accepted", strip_acc, 2560);
    chk("b_consecutive", 32'(last_acc_cyc - first_acc + 1), 32'd2560);
    chk("b_done_once", 32'(done_count - d0), 32'd1);
    chk("b_queue_empty", q.size(), 0);
    repeat (3) cyc();
    chk("b_idle", s_busy, 1'b0);

    // Random backpressure, buffer 1
    d0 = done_count;
    rnd_ready = 1'b1;
    start_strip();
    run_to_done(12000);
    rnd_ready = 1'b0;
    px_ready = 1'b1;
    chk("c_accepted", strip_acc, 2560);
    chk("c_queue_empty", q.size(), 0);
    chk("c_no_overrun", ovr_count, 0);
    chk("c_done_once", 32'(done_count - d0), 32'd1);
    repeat (2) cyc();

    // 20-cycle stall mid-MCU
    start_strip();
    repeat (300) cyc();
    px_ready = 1'b0;
    rd0 = rd_total;
    cyc();
    hold = {s_data, s_first, s_last, s_mcu};
    chk("d_valid_at_stall", s_valid, 1'b1);
    for (int i = 1; i < 20; i++) begin
      cyc();
      chk("d_stall_valid", s_valid, 1'b1);
      chk("d_stall_hold", {s_data, s_first, s_last, s_mcu}, hold);
    end
    chk("d_stall_reads_le2", (rd_total - rd0) <= 2, 1'b1);
    px_ready = 1'b1;
    run_to_done(3000);
    chk("d_accepted", strip_acc, 2560);
    chk("d_queue_empty", q.size(), 0);
    repeat (2) cyc();

    // Second swap at pixel 1000
    d0 = done_count;
    o0 = ovr_count;
    start_strip();
    n = 0;
    while (strip_acc < 1000 && n < 3000) begin
      cyc();
      n++;
    end
    chk("e_reached_1000", strip_acc, 1000);
    start_strip();
    cyc();
    chk("e_overrun_pulse", s_ovr, 1'b1);
    chk("e_sticky", s_sticky, 1'b1);
    cyc();
    chk("e_overrun_one_cycle", s_ovr, 1'b0);
    chk("e_sticky_held", s_sticky, 1'b1);
    chk("e_no_done_aborted", 32'(done_count - d0), 32'd0);
    run_to_done(3000);
    chk("e_accepted", strip_acc, 2560);
    chk("e_overrun_count", 32'(ovr_count - o0), 32'd1);
    chk("e_done_once", 32'(done_count - d0), 32'd1);
    repeat (2) cyc();

    // Swap on the exact cycle of the final pop
    d0 = done_count;
    o0 = ovr_count;
    start_strip();
    n = 0;
    while (strip_acc < 2559 && n < 3000) begin
      cyc();
      n++;
    end
    chk("f_reached_2559", strip_acc, 2559);
    chk("f_last_pending", q.size(), 1);
    start_strip();
    chk("f_old_queue_drained", 32'(done_count - d0), 32'd0);
    cyc();
    chk("f_strip_done", s_done, 1'b1);
    chk("f_no_overrun", s_ovr, 1'b0);
    chk("f_restart_busy", s_busy, 1'b1);
    chk("f_restart_buffer", s_buf, exp_buf);
    run_to_done(3000);
    chk("f_accepted", strip_acc, 2560);
    chk("f_overrun_count", 32'(ovr_count - o0), 32'd0);
    chk("f_done_twice", 32'(done_count - d0), 32'd2);
    repeat (2) cyc();

    // Reset mid-RUN with the buffer select left alone
    d0 = done_count;
    start_strip();
    repeat (100) cyc();
    nreset = 1'b1;
    repeat (2) cyc();
    nreset = 1'b0;
    q.delete();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("g_all_zero", {s_busy, s_rden, s_valid, s_done, s_ovr, s_sticky, s_addr, s_blk, s_buf}, 19'd0);
    end
    chk("g_no_done", 32'(done_count - d0), 32'd0);
    $display("reset mid-run settled at cycle %0d", cyc_no);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
